// File: rtl/dma_copy_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dma_copy_engine_pkg
//  Purpose  : Shared constants for the word-copy DMA: MMIO register offsets,
//             CTRL/STATUS bit positions and copy-FSM state encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dma_copy_engine_pkg;

  // MMIO byte offsets inside the 32-byte register window
  localparam logic [4:0] DMA_SRC    = 5'h00;
  localparam logic [4:0] DMA_DST    = 5'h04;
  localparam logic [4:0] DMA_LEN    = 5'h08;
  localparam logic [4:0] DMA_CTRL   = 5'h0C;
  localparam logic [4:0] DMA_STATUS = 5'h10;
  localparam logic [4:0] DMA_CLR    = 5'h14;

  // CTRL / STATUS bit indices
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_ERR    = 2;

  // Copy FSM state encoding
  localparam int              ST_W       = 3;
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_RD_REQ  = 3'd1;
  localparam logic [ST_W-1:0] ST_RD_WAIT = 3'd2;
  localparam logic [ST_W-1:0] ST_WR_REQ  = 3'd3;
  localparam logic [ST_W-1:0] ST_FIN     = 3'd4;

endpackage
`default_nettype wire

// File: rtl/dma_copy_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : dma_mmio_if / dma_mem_if
//  Purpose  : dma_mmio_if carries CPU register accesses (s_we, s_re, s_addr,
//             s_wdata in; s_rdata out of the DMA). dma_mem_if carries the DMA's
//             memory requests (m_req, m_we, m_addr, m_wdata out; m_gnt,
//             m_rvalid, m_rdata back from memory).
//             master = side that initiates, slave = side that responds.
//  Revision : 1.0 - initial release
// ============================================================================
interface dma_mmio_if #(
  parameter int DATA_W = 32
);
  logic              s_we;
  logic              s_re;
  logic [4:0]        s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;

  modport master (output s_we, s_re, s_addr, s_wdata, input  s_rdata);
  modport slave  (input  s_we, s_re, s_addr, s_wdata, output s_rdata);
endinterface

interface dma_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport master (output m_req, m_we, m_addr, m_wdata, input  m_gnt, m_rvalid, m_rdata);
  modport slave  (input  m_req, m_we, m_addr, m_wdata, output m_gnt, m_rvalid, m_rdata);
endinterface
`default_nettype wire

// File: rtl/dma_copy_engine_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : dma_copy_engine_regfile
//  Purpose  : MMIO decode and software-visible state of the copy DMA.
//  Ports    : clk, rst_n      clock / async active-low reset
//             mmio            register access port (slave)
//             fin             copy engine finished this cycle
//             src, dst        programmed addresses
//             words           LEN in words (LEN[1:0] dropped)
//             start_ok        accepted START that needs bus traffic
//             busy/done/irq_en status and interrupt enable
//  Revision : 1.0 - initial release
// ============================================================================
module dma_copy_engine_regfile
  import dma_copy_engine_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dma_mmio_if.slave         mmio,
  input  logic              fin,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-3:0]  words,
  output logic              start_ok,
  output logic              busy,
  output logic              done,
  output logic              irq_en
);

  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              irq_en_q, irq_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              wr_src, wr_dst, wr_len, wr_ctrl, wr_clr;
  logic              start_req, misaligned, zero_len;
  logic              unused_re;

  // Reads are side-effect free, so the read strobe carries no information.
  assign unused_re = mmio.s_re;

  assign wr_src  = mmio.s_we && (mmio.s_addr == DMA_SRC);
  assign wr_dst  = mmio.s_we && (mmio.s_addr == DMA_DST);
  assign wr_len  = mmio.s_we && (mmio.s_addr == DMA_LEN);
  assign wr_ctrl = mmio.s_we && (mmio.s_addr == DMA_CTRL);
  assign wr_clr  = mmio.s_we && (mmio.s_addr == DMA_CLR);

  assign words      = len_q[LEN_W-1:2];
  assign misaligned = (src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00);
  assign zero_len   = (words == '0);
  assign start_req  = wr_ctrl && mmio.s_wdata[CTRL_START] && !busy_q;
  assign start_ok   = start_req && !misaligned && !zero_len;

  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    if (!busy_q) begin
      if (wr_src) src_d = mmio.s_wdata[ADDR_W-1:0];
      if (wr_dst) dst_d = mmio.s_wdata[ADDR_W-1:0];
      if (wr_len) len_d = mmio.s_wdata[LEN_W-1:0];
    end
    if (wr_ctrl) irq_en_d = mmio.s_wdata[CTRL_IRQ_EN];
    // While busy DONE is already 0, so CLR can only scrub a stale ERR.
    if (wr_clr) begin
      err_d = 1'b0;
      if (!busy_q) done_d = 1'b0;
    end
    if (start_req) begin
      if (misaligned) begin
        err_d  = 1'b1;
        done_d = 1'b1;
      end else if (zero_len) begin
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        done_d = 1'b0;
        err_d  = 1'b0;
      end
    end
    // Completion is applied last so it beats a coincident CLR.
    if (fin) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      irq_en_q <= irq_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    mmio.s_rdata = '0;
    case (mmio.s_addr)
      DMA_SRC:    mmio.s_rdata = DATA_W'(src_q);
      DMA_DST:    mmio.s_rdata = DATA_W'(dst_q);
      DMA_LEN:    mmio.s_rdata = DATA_W'(len_q);
      DMA_CTRL:   mmio.s_rdata[CTRL_IRQ_EN] = irq_en_q;
      DMA_STATUS: begin
        mmio.s_rdata[STAT_BUSY] = busy_q;
        mmio.s_rdata[STAT_DONE] = done_q;
        mmio.s_rdata[STAT_ERR]  = err_q;
      end
      default:    mmio.s_rdata = '0;
    endcase
  end

  assign src    = src_q;
  assign dst    = dst_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign irq_en = irq_en_q;

endmodule
`default_nettype wire

// File: rtl/dma_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : dma_copy_engine
//  Purpose  : Memory-to-memory word-copy DMA. One word in flight: read the
//             source word, write it to the destination, advance, repeat.
//  Ports    : clk, rst_n  clock / async active-low reset
//             mmio        CPU register port (slave)
//             mem         memory request port (master)
//             irq         level interrupt = DONE & IRQ_EN
//  Revision : 1.0 - initial release
// ============================================================================
module dma_copy_engine
  import dma_copy_engine_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  dma_mmio_if.slave  mmio,
  dma_mem_if.master  mem,
  output logic       irq
);

  localparam int RW = LEN_W - 2;

  logic [ADDR_W-1:0] src, dst;
  logic [RW-1:0]     words;
  logic              start_ok, busy, done, irq_en, fin;

  logic [ST_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [RW-1:0]     remaining_q, remaining_d;
  logic              m_req_q, m_req_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

  dma_copy_engine_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .mmio     (mmio),
    .fin      (fin),
    .src      (src),
    .dst      (dst),
    .words    (words),
    .start_ok (start_ok),
    .busy     (busy),
    .done     (done),
    .irq_en   (irq_en)
  );

  assign fin = (state_q == ST_FIN);
  assign irq = done && irq_en;

  // Request outputs are registered and only change on a grant (or on entry
  // to a request state), so they hold steady while memory stalls.
  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    remaining_d = remaining_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          cur_src_d   = src;
          cur_dst_d   = dst;
          remaining_d = words;
          m_req_d     = 1'b1;
          m_we_d      = 1'b0;
          m_addr_d    = src;
          state_d     = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (mem.m_gnt) begin
          m_req_d = 1'b0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (mem.m_rvalid) begin
          m_wdata_d = mem.m_rdata;
          m_req_d   = 1'b1;
          m_we_d    = 1'b1;
          m_addr_d  = cur_dst_q;
          state_d   = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (mem.m_gnt) begin
          cur_src_d   = cur_src_q + ADDR_W'(4);
          cur_dst_d   = cur_dst_q + ADDR_W'(4);
          remaining_d = remaining_q - RW'(1);
          m_we_d      = 1'b0;
          if (remaining_q == RW'(1)) begin
            m_req_d = 1'b0;
            state_d = ST_FIN;
          end else begin
            m_req_d  = 1'b1;
            m_addr_d = cur_src_q + ADDR_W'(4);
            state_d  = ST_RD_REQ;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      remaining_q <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      remaining_q <= remaining_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
    end
  end

  assign mem.m_req   = m_req_q;
  assign mem.m_we    = m_we_q;
  assign mem.m_addr  = m_addr_q;
  assign mem.m_wdata = m_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_copy_engine
//  Purpose  : Scoreboard bench for dma_copy_engine. Stimulus predicts every bus
//             transaction of a copy (forward word copy over a reference memory)
//             and queues it; a monitor pops and compares on each grant.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_copy_engine;
  import dma_copy_engine_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic irq;
  always #5 clk = ~clk;

  dma_mmio_if #(.DATA_W(32))              mmio ();
  dma_mem_if  #(.ADDR_W(32), .DATA_W(32)) mem ();

  dma_copy_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mmio  (mmio),
    .mem   (mem),
    .irq   (irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  xact_t       exp_q[$];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int checks = 0, errors = 0;
  int req_cycles = 0, wr_hs = 0;
  int fixed_wait = -1;

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
  endfunction
  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : pattern(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory responder: random (or fixed) grant stall, read data 1..3 cycles after grant.
  initial begin
    int          stall;
    bit          loaded;
    bit          rd_pend;
    int          rd_dly;
    logic [31:0] rd_addr;
    mem.m_gnt = 1'b0; mem.m_rvalid = 1'b0; mem.m_rdata = '0;
    loaded = 0; rd_pend = 0; stall = 0; rd_dly = 0; rd_addr = '0;
    forever begin
      @(negedge clk);
      mem.m_gnt = 1'b0; mem.m_rvalid = 1'b0;
      if (!rst_n) begin
        loaded = 0; rd_pend = 0;
      end else begin
        if (rd_pend) begin
          if (rd_dly == 0) begin
            mem.m_rvalid = 1'b1; mem.m_rdata = bus_rd(rd_addr); rd_pend = 0;
          end else rd_dly--;
        end
        if (mem.m_req && !rd_pend) begin
          if (!loaded) begin
            stall  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
            loaded = 1;
          end
          if (stall == 0) begin
            mem.m_gnt = 1'b1; loaded = 0;
            if (mem.m_we) bus_mem[mem.m_addr] = mem.m_wdata;
            else begin
              rd_pend = 1; rd_addr = mem.m_addr; rd_dly = int'($urandom_range(0, 2));
            end
          end else stall--;
        end
      end
    end
  end

  // Monitor: compares each granted request with the scoreboard head and
  // checks that a stalled request holds its fields.
  initial begin
    bit          prev_stall;
    logic        prev_we;
    logic [31:0] prev_addr, prev_data;
    xact_t       e;
    prev_stall = 0; prev_we = 0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) prev_stall = 0;
      else begin
        if (prev_stall) begin
          check("stall_req",   {31'b0, mem.m_req}, 32'd1);
          check("stall_we",    {31'b0, mem.m_we}, {31'b0, prev_we});
          check("stall_addr",  mem.m_addr, prev_addr);
          check("stall_wdata", mem.m_wdata, prev_data);
        end
        if (mem.m_req) req_cycles++;
        if (mem.m_req && mem.m_gnt) begin
          prev_stall = 0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: addr %h we %0d, none expected", mem.m_addr, mem.m_we);
          end else begin
            e = exp_q.pop_front();
            check("bus_we",   {31'b0, mem.m_we}, {31'b0, e.we});
            check("bus_addr", mem.m_addr, e.addr);
            if (e.we) begin
              check("bus_wdata", mem.m_wdata, e.data);
              wr_hs++;
            end
          end
        end else if (mem.m_req) begin
          prev_stall = 1; prev_we = mem.m_we; prev_addr = mem.m_addr; prev_data = mem.m_wdata;
        end else prev_stall = 0;
      end
    end
  end

  task automatic mmio_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    mmio.s_we = 1'b1; mmio.s_addr = a; mmio.s_wdata = d;
    @(negedge clk);
    mmio.s_we = 1'b0;
  endtask

  task automatic mmio_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    mmio.s_re = 1'b1; mmio.s_addr = a;
    #1 d = mmio.s_rdata;
    mmio.s_re = 1'b0;
  endtask

  // Program registers, predict the copy in the reference model, then start.
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] len, input logic [31:0] ctrl);
    int n;
    logic [31:0] v;
    mmio_write(DMA_SRC, s);
    mmio_write(DMA_DST, d);
    mmio_write(DMA_LEN, len);
    n = int'(len[15:2]);
    if (ctrl[0] && s[1:0] == 2'b00 && d[1:0] == 2'b00) begin
      for (int i = 0; i < n; i++) begin
        v = ref_rd(s + 32'(4 * i));
        exp_q.push_back('{we: 1'b0, addr: s + 32'(4 * i), data: 32'h0});
        exp_q.push_back('{we: 1'b1, addr: d + 32'(4 * i), data: v});
        ref_mem[d + 32'(4 * i)] = v;
      end
    end
    mmio_write(DMA_CTRL, ctrl);
  endtask

  task automatic wait_done(input string name);
    logic [31:0] st;
    int n;
    st = '0;
    for (n = 0; n < 3000; n++) begin
      mmio_read(DMA_STATUS, st);
      if (!st[STAT_BUSY]) break;
    end
    if (n == 3000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: status %h still busy, required idle", name, st);
    end
    check({name, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_dst(input string name, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++)
      check(name, bus_rd(d + 32'(4 * i)), ref_rd(d + 32'(4 * i)));
  endtask

  task automatic check_status(input string name, input logic [31:0] exp_st, input logic exp_irq);
    logic [31:0] st;
    mmio_read(DMA_STATUS, st);
    check({name, "_status"}, st, exp_st);
    check({name, "_irq"}, {31'b0, irq}, {31'b0, exp_irq});
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, s, d, len, ctrl;
    int rc, base, n;
    rst_n = 1'b0;
    mmio.s_we = 1'b0; mmio.s_re = 1'b0; mmio.s_addr = '0; mmio.s_wdata = '0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_m_req",   {31'b0, mem.m_req}, 32'd0);
    check("rst_m_we",    {31'b0, mem.m_we}, 32'd0);
    check("rst_m_addr",  mem.m_addr, 32'd0);
    check("rst_m_wdata", mem.m_wdata, 32'd0);
    check("rst_irq",     {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    mmio_read(DMA_SRC, rd);    check("rst_src", rd, 32'd0);
    mmio_read(DMA_LEN, rd);    check("rst_len", rd, 32'd0);
    mmio_read(DMA_CTRL, rd);   check("rst_ctrl", rd, 32'd0);
    mmio_read(DMA_STATUS, rd); check("rst_status", rd, 32'd0);

    // 1: basic 4-word copy with interrupt
    for (int i = 0; i < 4; i++) begin
      bus_mem[32'h200 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
      ref_mem[32'h200 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
    end
    start_copy(32'h200, 32'h300, 32'h10, 32'h3);
    mmio_read(DMA_CTRL, rd); check("t1_ctrl_start_reads0", rd, 32'h2);
    wait_done("t1");
    check_status("t1", 32'h2, 1'b1);
    check_dst("t1_dst", 32'h300, 4);
    check("t1_last_word", bus_rd(32'h30C), 32'h4444_4444);
    mmio_write(DMA_CLR, 32'h0);
    check_status("t1_clr", 32'h0, 1'b0);

    // 2: zero-length copy completes immediately without bus traffic
    rc = req_cycles;
    start_copy(32'h200, 32'h300, 32'h0, 32'h3);
    check("t2_irq_next", {31'b0, irq}, 32'd1);
    check_status("t2", 32'h2, 1'b1);
    repeat (3) @(negedge clk);
    check("t2_no_req", req_cycles, rc);
    mmio_write(DMA_CLR, 32'h0);

    // 3: misaligned source
    start_copy(32'h202, 32'h300, 32'h10, 32'h3);
    check_status("t3", 32'h6, 1'b1);
    repeat (3) @(negedge clk);
    check("t3_no_req", req_cycles, rc);
    mmio_write(DMA_CLR, 32'h0);
    check_status("t3_clr", 32'h0, 1'b0);

    // 4: five-cycle grant stall on every request
    fixed_wait = 5;
    rc = req_cycles;
    start_copy(32'h400, 32'h480, 32'h10, 32'h3);
    wait_done("t4");
    check_dst("t4_dst", 32'h480, 4);
    check("t4_stalled", {31'b0, (req_cycles - rc) >= 48}, 32'd1);
    check_status("t4", 32'h2, 1'b1);
    mmio_write(DMA_CLR, 32'h0);

    // 5: register writes while busy are ignored; CTRL still latches IRQ_EN
    fixed_wait = 3;
    start_copy(32'h200, 32'h600, 32'h10, 32'h3);
    mmio_write(DMA_DST, 32'h500);
    mmio_write(DMA_CTRL, 32'h1);
    wait_done("t5");
    fixed_wait = -1;
    mmio_read(DMA_DST, rd); check("t5_dst_reg", rd, 32'h600);
    check_dst("t5_dst", 32'h600, 4);
    check("t5_500_untouched", {31'b0, bus_mem.exists(32'h500)}, 32'd0);
    check_status("t5", 32'h2, 1'b0);
    mmio_write(DMA_CLR, 32'h0);

    // 6: reset after word 2 of 4, then a full restart
    mmio_write(DMA_CTRL, 32'h2);
    start_copy(32'h200, 32'h700, 32'h10, 32'h3);
    base = wr_hs;
    for (n = 0; n < 500; n++) begin
      @(negedge clk); #2;
      if (wr_hs >= base + 2) break;
    end
    if (n == 500) begin
      checks++; errors++;
      $display("FAIL t6_wait: writes %0d, required %0d", wr_hs - base, 2);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check("t6_req_async_drop", {31'b0, mem.m_req}, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    check_status("t6_rst", 32'h0, 1'b0);
    mmio_read(DMA_SRC, rd); check("t6_src_rst", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start_copy(32'h200, 32'h700, 32'h10, 32'h3);
    wait_done("t6");
    check_dst("t6_dst", 32'h700, 4);

    // 7: CLR landing on the completion cycle, then IRQ_EN=0 copy
    mmio_write(DMA_CLR, 32'h0);
    start_copy(32'h200, 32'h780, 32'h10, 32'h3);
    for (n = 0; n < 500; n++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0) break;
    end
    mmio_write(DMA_CLR, 32'h0);
    check_status("t7_clr_fin", 32'h2, 1'b1);
    mmio_write(DMA_CLR, 32'h0);
    start_copy(32'h200, 32'h7C0, 32'h10, 32'h1);
    wait_done("t7b");
    check_status("t7b", 32'h2, 1'b0);
    check_dst("t7b_dst", 32'h7C0, 4);
    mmio_write(DMA_CLR, 32'h0);

    // Random copies (possibly overlapping), plus one wrapping past 2^32
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        s = 32'hFFFF_FFF8; d = 32'hFFFF_FFFC; len = 32'h10;
      end else begin
        s   = 32'h1000_0000 + {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        d   = 32'h1000_0000 + {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        len = 32'($urandom_range(0, 40)) | ($urandom & 32'hFFFF_0000);
      end
      ctrl = {30'b0, 1'($urandom_range(0, 1)), 1'b1};
      start_copy(s, d, len, ctrl);
      mmio_read(DMA_LEN, rd); check("rnd_len_reg", rd, {16'b0, len[15:0]});
      wait_done("rnd");
      check_status("rnd", 32'h2, ctrl[1]);
      check_dst("rnd_dst", d, int'(len[15:2]));
      mmio_write(DMA_CLR, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
